// File: rtl/seg7_scan_n_if.sv
// Display-driver bundle: packed hex word, decimal points and brightness in,
// anode/segment pins and frame strobe out.
interface seg7_scan_n_if #(
  parameter int DIGITS = 4
) ();
  logic [4*DIGITS-1:0] num;
  logic [DIGITS-1:0]   dp;
  logic                blank_lz;
  logic [3:0]          bright;
  logic [6:0]          sseg;
  logic                sdp;
  logic [DIGITS-1:0]   an;
  logic                frame;

  modport master (
    output num, dp, blank_lz, bright,
    input  sseg, sdp, an, frame
  );

  modport slave (
    input  num, dp, blank_lz, bright,
    output sseg, sdp, an, frame
  );
endinterface

// File: rtl/seg7_scan_n.sv
// Multiplexed common-anode seven-segment scanner with frame-synchronous
// shadowing of the digit word, leading-zero blanking and 16-level PWM.
module seg7_scan_n #(
  parameter int DIGITS         = 4,
  parameter int DIV_BITS       = 16,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  seg7_scan_n_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_BITS-1:0] r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_num_s;
  logic [DIGITS-1:0]   r_dp_s;
  logic [DIGITS-1:0]   r_an;
  logic [6:0]          r_sseg;
  logic                r_sdp;
  logic                r_frame;

  logic                w_tick;
  logic                w_frame_end;
  logic                w_on;
  logic                w_blank;
  logic [3:0]          w_nib;
  logic [6:0]          w_seg_hi;
  logic [DIGITS-1:0]   w_an_hi;
  logic [3:0]          w_nibs [DIGITS];
  logic [DIGITS-1:0]   w_zero_from;

  assign w_tick      = &r_cnt;
  assign w_frame_end = w_tick && (r_idx == LAST_IDX);
  assign w_on        = r_cnt[DIV_BITS-1 -: 4] < bus.bright;

  // w_zero_from[i]: every nibble from i up to the most significant is zero
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
      assign w_nibs[gi]      = r_num_s[4*gi +: 4];
      assign w_zero_from[gi] = (r_num_s[4*DIGITS-1 : 4*gi] == '0);
    end
  endgenerate

  assign w_nib   = w_nibs[r_idx];
  assign w_blank = (r_idx != '0) && bus.blank_lz && w_zero_from[r_idx];

  always_comb begin
    w_seg_hi = 7'h00;
    if (!w_blank) begin
      case (w_nib)
        4'h0: w_seg_hi = 7'h3F;
        4'h1: w_seg_hi = 7'h06;
        4'h2: w_seg_hi = 7'h5B;
        4'h3: w_seg_hi = 7'h4F;
        4'h4: w_seg_hi = 7'h66;
        4'h5: w_seg_hi = 7'h6D;
        4'h6: w_seg_hi = 7'h7D;
        4'h7: w_seg_hi = 7'h07;
        4'h8: w_seg_hi = 7'h7F;
        4'h9: w_seg_hi = 7'h6F;
        4'hA: w_seg_hi = 7'h77;
        4'hB: w_seg_hi = 7'h7C;
        4'hC: w_seg_hi = 7'h39;
        4'hD: w_seg_hi = 7'h5E;
        4'hE: w_seg_hi = 7'h79;
        default: w_seg_hi = 7'h71;
      endcase
    end
  end

  always_comb begin
    w_an_hi = '0;
    if (w_on) w_an_hi = DIGITS'(1) << r_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_tick) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // Reset keeps the shadow tracking the inputs so the first frame is valid
  always_ff @(posedge clk) begin
    if (rst || w_frame_end) begin
      r_num_s <= bus.num;
      r_dp_s  <= bus.dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_an    <= {DIGITS{AN_ACTIVE_LOW}};
      r_sseg  <= {7{SEG_ACTIVE_LOW}};
      r_sdp   <= SEG_ACTIVE_LOW;
      r_frame <= 1'b0;
    end else begin
      r_an    <= w_an_hi ^ {DIGITS{AN_ACTIVE_LOW}};
      r_sseg  <= w_seg_hi ^ {7{SEG_ACTIVE_LOW}};
      r_sdp   <= r_dp_s[r_idx] ^ SEG_ACTIVE_LOW;
      r_frame <= w_frame_end;
    end
  end

  assign bus.an    = r_an;
  assign bus.sseg  = r_sseg;
  assign bus.sdp   = r_sdp;
  assign bus.frame = r_frame;
endmodule
